// File: rtl/sig_pkg.sv
// Shared constants and types for the signature input parser.
// The secp256k1 order, legal recovery bytes, the error-code enumeration and the FSM states.
package sig_pkg;

  localparam int SIG_BYTES = 65;
  localparam int SIG_W     = SIG_BYTES * 8;

  localparam logic [255:0] N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] HALF_N =
    256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_5D576E73_57A4501D_DFE92F46_681B20A0;

  localparam logic [7:0] V_27 = 8'd27;
  localparam logic [7:0] V_28 = 8'd28;
  localparam logic [7:0] V_35 = 8'd35;
  localparam logic [7:0] V_36 = 8'd36;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_SHORT     = 3'd1,
    ERR_LONG      = 3'd2,
    ERR_R_RANGE   = 3'd3,
    ERR_S_RANGE   = 3'd4,
    ERR_V_ILLEGAL = 3'd5,
    ERR_HIGH_S    = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/sig_range_checker.sv
// Combinational validity checks on an unpacked {r, s, v} signature; lowest failing code wins.
// Defining LOW_S_CHECK_EN adds the high-s rejection (code 6) after the v check.
module sig_range_checker
  import sig_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  output logic             error,
  output err_code_e        code
);

  logic [255:0] r;
  logic [255:0] s;
  logic [7:0]   v;
  logic         v_legal;

  assign r = sig[519:264];
  assign s = sig[263:8];
  assign v = sig[7:0];

  assign v_legal = (v == V_27) || (v == V_28) || (v == V_35) || (v == V_36);

  always_comb begin
    code = ERR_NONE;
    if (r == '0 || r >= N)
      code = ERR_R_RANGE;
    else if (s == '0 || s >= N)
      code = ERR_S_RANGE;
    else if (!v_legal)
      code = ERR_V_ILLEGAL;
`ifdef LOW_S_CHECK_EN
    else if (s > HALF_N)
      code = ERR_HIGH_S;
`endif
  end

  assign error = (code != ERR_NONE);

endmodule

// File: rtl/sig_input_parser.sv
// Byte-serial signature parser: assembles a 65-byte {r, s, v} frame, checks it, holds the result.
// Optional high-s rejection is enabled by defining LOW_S_CHECK_EN (see sig_range_checker).
//
// state    | meaning
// ST_RECV  | accepting frame bytes 0..64
// ST_DRAIN | frame overran 65 bytes, discarding until byte_last
// ST_CHECK | one cycle to latch range-check / framing result
// ST_HOLD  | result presented, waiting for sig_out_ready
module sig_input_parser
  import sig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic             sig_out_valid,
  input  logic             sig_out_ready,
  output logic             sig_error,
  output logic [2:0]       err_code
);

  state_e           state, state_nxt;
  logic [6:0]       idx;
  logic [SIG_W-1:0] frame;
  err_code_e        frame_err;
  err_code_e        err_q;
  err_code_e        chk_code;
  logic             chk_error;
  logic             take;
  logic             at_last_slot;
  logic [9:0]       slot_lsb;

  sig_range_checker u_checker (
    .sig   (frame),
    .error (chk_error),
    .code  (chk_code)
  );

  assign byte_ready    = (state == ST_RECV) || (state == ST_DRAIN);
  assign take          = byte_valid && byte_ready;
  assign at_last_slot  = (idx == 7'(SIG_BYTES - 1));
  // Byte 0 sits in the top byte lane, so the lane offset counts down with idx.
  assign slot_lsb      = {3'b000, 7'(SIG_BYTES - 1) - idx} << 3;
  assign sig_out       = frame;
  assign sig_out_valid = (state == ST_HOLD);
  assign err_code      = err_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RECV: begin
        if (take) begin
          if (byte_last)
            state_nxt = ST_CHECK;
          else if (at_last_slot)
            state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (take && byte_last)
          state_nxt = ST_CHECK;
      end
      ST_CHECK: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (sig_out_valid && sig_out_ready)
          state_nxt = ST_RECV;
      end
      default: state_nxt = ST_RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RECV;
      idx       <= '0;
      frame     <= '0;
      frame_err <= ERR_NONE;
      sig_error <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_RECV: begin
          if (take) begin
            frame[slot_lsb +: 8] <= byte_in;
            if (byte_last) begin
              idx       <= '0;
              frame_err <= at_last_slot ? ERR_NONE : ERR_SHORT;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (take) begin
            if (byte_last) begin
              idx       <= '0;
              frame_err <= ERR_LONG;
            end else if (idx != '1) begin
              idx <= idx + 7'd1;
            end
          end
        end
        ST_CHECK: begin
          // Framing errors take precedence; range checks on a malformed frame are meaningless.
          if (frame_err != ERR_NONE) begin
            sig_error <= 1'b1;
            err_q     <= frame_err;
          end else begin
            sig_error <= chk_error;
            err_q     <= chk_code;
          end
        end
        ST_HOLD: begin
          if (sig_out_valid && sig_out_ready) begin
            frame     <= '0;
            frame_err <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sig_input_parser.md
SIG_INPUT_PARSER -- requirements
Module: sig_input_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 byte_in  in  8  serialized signature byte.
REQ-005 byte_valid  in  1  byte_in is valid this cycle.
REQ-006 byte_last  in  1  qualifies the final byte of a frame; meaningful only with byte_valid.
REQ-007 byte_ready  out  1  parser accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-008 sig_out  out  520  unpacked signature {r[255:0], s[255:0], v[7:0]}.
REQ-009 sig_out_valid  out  1  a result (good or error) is presented.
REQ-010 sig_out_ready  in  1  consumer accepts the result.
REQ-011 sig_error  out  1  the presented result is an error; qualified by sig_out_valid.
REQ-012 err_code  out  3  error cause: 0 none, 1 short frame, 2 long frame, 3 r range, 4 s range, 5 v illegal, 6 high-s.

Function
REQ-013 A frame SHALL be exactly 65 bytes, big-endian: bytes 0-31 are r, bytes 32-63 are s, byte 64 is v; byte 0 lands in sig_out[519:512].
REQ-014 FSM states and transitions SHALL be:
- RECV -> CHECK on accepting byte 64 with byte_last.
- RECV -> CHECK with err 1 on byte_last at index <64.
- RECV -> DRAIN on accepting byte 64 without byte_last.
- DRAIN discards bytes -> CHECK with err 2 when byte_last is accepted.
- CHECK -> HOLD after 1 cycle.
- HOLD -> RECV on sig_out_valid && sig_out_ready.
REQ-015 byte_ready SHALL be 1 in RECV and DRAIN and 0 in CHECK and HOLD.
REQ-016 The 7-bit byte index SHALL count accepted bytes, clear on frame end, and never wrap.
REQ-017 CHECK SHALL evaluate r!=0, r<N, s!=0, s<N and v in {27,28,35,36}, with N the secp256k1 order.
REQ-018 Error priority SHALL be lowest code first; framing errors skip range checks.
REQ-019 Latency: last byte accepted at cycle T -> sig_out_valid high at T+2.
REQ-020 In HOLD, sig_out, sig_error and err_code SHALL be stable until the handshake completes.
REQ-021 sig_out_valid SHALL deassert in the cycle after acceptance; a back-to-back frame's byte 0 can be accepted that cycle.
REQ-022 On a short frame, sig_out SHALL carry the partial bytes received and zeros elsewhere.
REQ-023 On err 2, sig_out SHALL hold the first 65 bytes.

Reset
REQ-024 On rst, the FSM SHALL enter RECV, the index SHALL clear to 0, and the partial frame SHALL be discarded.
REQ-025 Reset values: sig_out=0, sig_out_valid=0, sig_error=0, err_code=0; byte_ready=1 after reset deasserts.
REQ-026 Reset mid-frame or in HOLD SHALL drop any pending result without emitting it.

Configuration
REQ-027 With LOW_S_CHECK_EN defined, s > HALF_N SHALL raise err 6 (priority after 5).
REQ-028 Without LOW_S_CHECK_EN, high-s signatures SHALL pass and code 6 SHALL never be emitted.

Structure
REQ-029 Package sig_pkg SHALL hold: N, HALF_N, V_27/28/35/36, the err_code enumeration, SIG_BYTES=65 and the FSM state typedef.
REQ-030 Sub-module sig_range_checker SHALL hold the combinational r/s/v/low-s checks, with output {error, code}.

Verification
REQ-031 r=1, s=1, v=0x1B, last on byte 64 -> at T+2: valid=1, sig_out={256'h1,256'h1,8'h1B}, error=0.
REQ-032 byte_last on byte 9 -> valid, error=1, err_code=1; sig_out[519:440] = received bytes.
REQ-033 70-byte frame (last on byte 69) -> bytes 65-69 consumed with byte_ready=1; then err_code=2.
REQ-034 r=N, s=1, v=29 -> err_code=3 (priority); r=1, s=1, v=29 -> err_code=5.
REQ-035 s=HALF_N+1, r=1, v=27 -> err_code=6 with LOW_S_CHECK_EN; error=0 without it.
REQ-036 sig_out_ready low for 5 cycles -> outputs stable and byte_ready=0; then rst after 30 bytes of the next frame -> no output, and the following clean frame parses per REQ-031.
